bus_bridge_n: RTL

Parametrised system bridge between the CPU data-memory port and NDEV memory-mapped peripherals (timers, UART, switches, LEDs). Each device owns a word-aligned address window. Every access is latched, driven to the selected device with a read or write strobe held until that device acknowledges, and returned to the CPU with a registered response. Unmapped, misaligned and timed-out accesses complete with an error flag and a captured fault address. The CPU stalls while `pr_req && !pr_ready`.

---
 rtl/bridge_pkg.sv | 25 ++
 rtl/bridge_addr_decode.sv | 38 +++
 rtl/bus_bridge_n.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: state encoding,
// default address map and a constant-evaluable clog2.
package bridge_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam int unsigned SEL_W         = 3;
    localparam int unsigned DEF_NDEV      = 4;
    localparam int unsigned DEF_WIN_WORDS = 4;
    localparam logic [127:0] DEF_DEV_BASE =
        {32'h0000_7f30, 32'h0000_7f20, 32'h0000_7f10, 32'h0000_7f00};

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decoder: window hit, selected device index and
// word-alignment check for the incoming CPU address.
module bridge_addr_decode
    import bridge_pkg::*;
#(
    parameter int unsigned         NDEV      = DEF_NDEV,
    parameter logic [NDEV*32-1:0]  DEV_BASE  = DEF_DEV_BASE[NDEV*32-1:0],
    parameter int unsigned         WIN_WORDS = DEF_WIN_WORDS
) (
    input  logic [31:0]      i_pr_addr,
    output logic             o_hit,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_misaligned
);

    localparam logic [32:0] WIN_LAST = 33'(4 * WIN_WORDS - 1);

    logic [32:0] w_lo;
    logic [32:0] w_addr;

    assign w_addr       = {1'b0, i_pr_addr};
    assign o_misaligned = |i_pr_addr[1:0];

    // Scan from the top index down so the lowest overlapping window wins.
    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        w_lo  = '0;
        for (int unsigned i = NDEV; i > 0; i--) begin
            w_lo = {1'b0, DEV_BASE[(i-1)*32 +: 32]};
            if (w_addr >= w_lo && w_addr <= w_lo + WIN_LAST) begin
                o_hit = 1'b1;
                o_sel = SEL_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/bus_bridge_n.sv
// Bridge from the CPU data port to NDEV memory-mapped peripherals with
// held strobes, registered responses, timeout and fault-address capture.
module bus_bridge_n
    import bridge_pkg::*;
#(
    parameter int unsigned         NDEV      = DEF_NDEV,
    parameter logic [NDEV*32-1:0]  DEV_BASE  = DEF_DEV_BASE[NDEV*32-1:0],
    parameter int unsigned         WIN_WORDS = DEF_WIN_WORDS,
    parameter int unsigned         TIMEOUT   = 15,
    localparam int unsigned        AW        = clog2(WIN_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pr_req,
    input  logic                 pr_we,
    input  logic [31:0]          pr_addr,
    input  logic [31:0]          pr_wd,
    output logic [31:0]          pr_rd,
    output logic                 pr_ready,
    output logic                 pr_err,
    output logic [31:0]          err_addr,
    output logic [AW-1:0]        dev_addr,
    output logic [31:0]          dev_wd,
    output logic [NDEV-1:0]      dev_we,
    output logic [NDEV-1:0]      dev_re,
    input  logic [NDEV*32-1:0]   dev_rd,
    input  logic [NDEV-1:0]      dev_ack
);

    localparam int unsigned    CW      = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = '1;

    logic [1:0]        r_state;
    logic [SEL_W-1:0]  r_sel;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [CW-1:0]     r_cnt;
    logic [NDEV-1:0]   r_dev_we;
    logic [NDEV-1:0]   r_dev_re;
    logic [AW-1:0]     r_dev_addr;
    logic [31:0]       r_dev_wd;
    logic [31:0]       r_rd;
    logic              r_ready;
    logic              r_err;
    logic [31:0]       r_err_addr;

    logic              w_hit;
    logic [SEL_W-1:0]  w_sel;
    logic              w_mis;
    logic              w_ack;
    logic [31:0]       w_rdata;
    logic [NDEV-1:0]   w_onehot;
    logic              w_timeout;

    bridge_addr_decode #(
        .NDEV      (NDEV),
        .DEV_BASE  (DEV_BASE),
        .WIN_WORDS (WIN_WORDS)
    ) u_decode (
        .i_pr_addr    (pr_addr),
        .o_hit        (w_hit),
        .o_sel        (w_sel),
        .o_misaligned (w_mis)
    );

    always_comb begin
        w_ack    = 1'b0;
        w_rdata  = '0;
        w_onehot = '0;
        for (int unsigned i = 0; i < NDEV; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_ack   = dev_ack[i];
                w_rdata = dev_rd[i*32 +: 32];
            end
            if (w_sel == SEL_W'(i)) w_onehot[i] = 1'b1;
        end
    end

    // r_cnt counts completed BUSY cycles, so the strobe lasts TIMEOUT cycles.
    assign w_timeout = (TIMEOUT != 0) && (32'(r_cnt) + 32'd1 >= TIMEOUT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_dev_we   <= '0;
            r_dev_re   <= '0;
            r_dev_addr <= '0;
            r_dev_wd   <= '0;
            r_rd       <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (pr_req) begin
                        if (w_hit && !w_mis) begin
                            r_sel      <= w_sel;
                            r_we       <= pr_we;
                            r_addr     <= pr_addr;
                            r_dev_addr <= pr_addr[AW+1:2];
                            r_dev_wd   <= pr_wd;
                            r_dev_we   <= pr_we ? w_onehot : '0;
                            r_dev_re   <= pr_we ? '0 : w_onehot;
                            r_cnt      <= '0;
                            r_state    <= ST_BUSY;
                        end else begin
                            r_err_addr <= pr_addr;
                            r_rd       <= '0;
                            r_ready    <= 1'b1;
                            r_err      <= 1'b1;
                            r_state    <= ST_FAULT;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_ack) begin
                        r_rd     <= r_we ? '0 : w_rdata;
                        r_dev_we <= '0;
                        r_dev_re <= '0;
                        r_ready  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (w_timeout) begin
                        r_err_addr <= r_addr;
                        r_rd       <= '0;
                        r_dev_we   <= '0;
                        r_dev_re   <= '0;
                        r_ready    <= 1'b1;
                        r_err      <= 1'b1;
                        r_state    <= ST_FAULT;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pr_rd    = r_rd;
    assign pr_ready = r_ready;
    assign pr_err   = r_err;
    assign err_addr = r_err_addr;
    assign dev_addr = r_dev_addr;
    assign dev_wd   = r_dev_wd;
    assign dev_we   = r_dev_we;
    assign dev_re   = r_dev_re;

endmodule
